// File: rtl/seg7_pkg.sv
// ============================================================================
// seg7_pkg : glyph constants, bit-order constants and the code-to-glyph function
// Optional feature macro: SEG7_HEX_EN (codes 10..15 shown as A b C d E F)
// Revision : 1.0
// ============================================================================
`default_nettype none

package seg7_pkg;

   localparam int SEG_GLYPH_W = 7;   // {g,f,e,d,c,b,a}
   localparam int SEG_DP_BIT  = 7;   // dp sits above the glyph in ledCode

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic {
      PHASE_ON  = 1'b0,
      PHASE_OFF = 1'b1
   } blink_phase_t;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] code);
      logic [6:0] seg;
      case (code)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
`ifdef SEG7_HEX_EN
         4'd10:   seg = SEG_A;
         4'd11:   seg = SEG_B;
         4'd12:   seg = SEG_C;
         4'd13:   seg = SEG_D;
         4'd14:   seg = SEG_E;
         4'd15:   seg = SEG_F;
`endif
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decoder.sv
// ============================================================================
// seg7_decoder : combinational 4-bit code to active-low 7-segment glyph
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_decoder
   import seg7_pkg::*;
(
   input  logic [3:0]             code,
   output logic [SEG_GLYPH_W-1:0] seg_n
);

   assign seg_n = hex_to_seg(code);

endmodule

`default_nettype wire

// File: rtl/seg7_scan_driver.sv
// ============================================================================
// seg7_scan_driver : 8-digit multiplexed common-anode driver with dots/blink
// Optional feature macro: SEG7_HEX_EN (hex glyphs for codes 10..15)
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int SCAN_DIV  = 50_000,
   parameter int BLINK_DIV = 12_500_000
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] led0,
   input  logic [3:0] led1,
   input  logic [3:0] led2,
   input  logic [3:0] led3,
   input  logic [3:0] led4,
   input  logic [3:0] led5,
   input  logic [3:0] led6,
   input  logic [3:0] led7,
   input  logic [7:0] dot,
   input  logic [7:0] blink,
   output logic [7:0] ledCode,
   output logic [7:0] an
);

   // A divider of 1 still needs a 1-bit counter that stays at zero.
   localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   logic [SCAN_W-1:0]      scan_cnt;
   logic [BLINK_W-1:0]     blink_cnt;
   logic [2:0]             index;
   blink_phase_t           phase;
   logic [3:0]             cur_code;
   logic [SEG_GLYPH_W-1:0] cur_seg;
   logic                   blanked;

   always_comb begin
      cur_code = led0;
      case (index)
         3'd0: cur_code = led0;
         3'd1: cur_code = led1;
         3'd2: cur_code = led2;
         3'd3: cur_code = led3;
         3'd4: cur_code = led4;
         3'd5: cur_code = led5;
         3'd6: cur_code = led6;
         3'd7: cur_code = led7;
      endcase
   end

   assign blanked = blink[index] && (phase == PHASE_OFF);

   seg7_decoder u_decoder (
      .code  (cur_code),
      .seg_n (cur_seg)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scan_cnt  <= '0;
         blink_cnt <= '0;
         index     <= 3'd0;
         phase     <= PHASE_ON;
         an        <= 8'hFF;
         ledCode   <= 8'hFF;
      end else begin
         if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            index    <= index + 3'd1;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end

         // Independent of the scan counter so coincident wraps both apply.
         if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase     <= (phase == PHASE_ON) ? PHASE_OFF : PHASE_ON;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end

         if (blanked) begin
            an      <= 8'hFF;
            ledCode <= 8'hFF;
         end else begin
            an                            <= ~(8'b1 << index);
            ledCode[SEG_DP_BIT]           <= ~dot[index];
            ledCode[SEG_GLYPH_W-1:0]      <= cur_seg;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// ============================================================================
// tb_seg7_scan_driver : self-checking bench with a cycle-count reference model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seg7_scan_driver;

   localparam int SCAN_DIV  = 4;
   localparam int BLINK_DIV = 64;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] led [8];
   logic [7:0] dot;
   logic [7:0] blink;
   logic [7:0] ledCode;
   logic [7:0] an;

   int k;        // clock edges since the last reset release
   int passed;
   int failed;
   int total;

   logic [7:0] an_tab   [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
   logic [7:0] code_tab [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

   always #5 clk = ~clk;

   seg7_scan_driver #(
      .SCAN_DIV  (SCAN_DIV),
      .BLINK_DIV (BLINK_DIV)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .led0    (led[0]),
      .led1    (led[1]),
      .led2    (led[2]),
      .led3    (led[3]),
      .led4    (led[4]),
      .led5    (led[5]),
      .led6    (led[6]),
      .led7    (led[7]),
      .dot     (dot),
      .blink   (blink),
      .ledCode (ledCode),
      .an      (an)
   );

   function automatic logic [6:0] glyph(input logic [3:0] c);
      logic [6:0] tbl [16];
      tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10,
`ifdef SEG7_HEX_EN
              7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`else
              7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`endif
      return tbl[c];
   endfunction

   function automatic int cur_slot();
      return ((k - 1) / SCAN_DIV) % 8;
   endfunction

   function automatic bit cur_off();
      return (((k - 1) / BLINK_DIV) % 2) == 1;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%02h expected=%02h (k=%0d)", tag, obs, exp, k);
      end
   endtask

   // Advance one clock, then compare the pins against the model.
   task automatic step(input string tag);
      int s;
      logic [7:0] ea, el;
      @(posedge clk);
      k++;
      @(negedge clk);
      s = cur_slot();
      if (cur_off() && blink[s]) begin
         ea = 8'hFF;
         el = 8'hFF;
      end else begin
         ea    = 8'hFF;
         ea[s] = 1'b0;
         el    = {~dot[s], glyph(led[s])};
      end
      check({tag, "_an"}, an, ea);
      check({tag, "_code"}, ledCode, el);
   endtask

   initial begin
      int guard;
      passed = 0; failed = 0; total = 0; k = 0;
      dot = 8'h00; blink = 8'h00;
      for (int i = 0; i < 8; i++) led[i] = 4'(i);

      // 1: reset state, then first digit one clock after release
      repeat (3) @(negedge clk);
      check("reset_an", an, 8'hFF);
      check("reset_code", ledCode, 8'hFF);
      reset = 1'b0;
      k = 0;
      step("first");
      check("first_an_const", an, 8'hFE);
      check("first_code_const", ledCode, 8'hC0);

      // 2: one full frame of digits 0..7
      for (int i = 1; i < 32; i++) begin
         step("frame");
         check("frame_an_const", an, an_tab[cur_slot()]);
         check("frame_code_const", ledCode, code_tab[cur_slot()]);
      end
      step("wrap");
      check("wrap_an_const", an, 8'hFE);

      // 3: decimal point on digit 2 showing 8
      dot = 8'h04; led[2] = 4'd8;
      for (int i = 0; i < 31; i++) begin
         step("dot");
         if (an == 8'hFB) check("dot_slot2_const", ledCode, 8'h00);
      end

      // 4: blink digit 0 across an ON and an OFF phase
      blink = 8'h01; led[0] = 4'd5;
      for (int i = 0; i < 128; i++) begin
         step("blink");
         if (cur_slot() == 0 && cur_off()) check("blink_off_const", an, 8'hFF);
         if (cur_slot() == 0 && !cur_off()) check("blink_on_const", ledCode, 8'h92);
      end

      // 5: code 12 on digit 3
      led[3] = 4'hC;
      for (int i = 0; i < 32; i++) begin
         step("hex");
`ifdef SEG7_HEX_EN
         if (cur_slot() == 3) check("hex_c_const", ledCode, 8'hC6);
`else
         if (cur_slot() == 3) check("hex_c_const", ledCode, 8'hFF);
`endif
      end

      // 6: asynchronous reset in the middle of slot 5
      guard = 0;
      while (!(cur_slot() == 5 && ((k - 1) % SCAN_DIV) == 1) && guard < 64) begin
         step("seek5");
         guard++;
      end
      check("seek5_an", an, 8'hDF);
      #2 reset = 1'b1;
      #1;
      check("async_rst_an", an, 8'hFF);
      check("async_rst_code", ledCode, 8'hFF);
      @(negedge clk);
      check("held_rst_an", an, 8'hFF);
      reset = 1'b0;
      k = 0;
      step("restart");
      check("restart_an_const", an, 8'hFE);
      check("restart_code_const", ledCode, 8'h92);

      // Randomized inputs changing mid-slot, checked every cycle
      for (int i = 0; i < 320; i++) begin
         led[$urandom_range(7, 0)] = 4'($urandom);
         if ($urandom_range(3, 0) == 0) dot = 8'($urandom);
         if ($urandom_range(7, 0) == 0) blink = 8'($urandom);
         step("rand");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
